// File: rtl/disp_arb_pkg.sv
// Shared types for the display arbiter: grant state enum, mux select codes.
// Exposes state_e, SEL_DICE/SEL_LIGHTS and sel_of() mapping a grant to its select.
package disp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GNT_DICE   = 2'd1,
    GNT_LIGHTS = 2'd2
  } state_e;

  localparam logic SEL_DICE   = 1'b0;
  localparam logic SEL_LIGHTS = 1'b1;

  function automatic logic sel_of(input state_e s);
    return (s == GNT_LIGHTS) ? SEL_LIGHTS : SEL_DICE;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Down-counter used for the grant dwell and the idle auto-rotate period.
// Ports: clk, rst (sync, active-low), load (reload DWELL_CYCLES-1), zero (count is 0).
module dwell_timer #(
  parameter int DWELL_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic zero
);

  localparam int CNT_W = $clog2(DWELL_CYCLES + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/display_arbiter.sv
// Round-robin arbiter with minimum dwell driving the dice/lights display select.
// Ports: clk, rst (sync, active-low), req_dice, req_lights -> sel, gnt_dice,
// gnt_lights, busy, switch_pulse. Define DISPLAY_ARB_AUTO_ROTATE_EN to let
// sel rotate while idle with no requests.
module display_arbiter
  import disp_arb_pkg::*;
#(
  parameter int DWELL_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req_dice,
  input  logic req_lights,
  output logic sel,
  output logic gnt_dice,
  output logic gnt_lights,
  output logic busy,
  output logic switch_pulse
);

  state_e state_q;
  state_e state_d;
  logic   sel_q;
  logic   sel_d;
  logic   pulse_q;
  logic   pulse_d;
  logic   last_q;
  logic   last_d;
  logic   load;
  logic   dwell_zero;
  logic   rot_toggle;

  dwell_timer #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .zero (dwell_zero)
  );

`ifdef DISPLAY_ARB_AUTO_ROTATE_EN
  logic idle_run;
  logic idle_zero;
  logic idle_load;

  assign idle_run = (state_q == IDLE) && !req_dice && !req_lights;
  // Held at reload whenever rotation is not running, so every idle
  // stretch (including the one right after reset) toggles after
  // exactly DWELL_CYCLES cycles.
  assign idle_load  = !rst || !idle_run || idle_zero;
  assign rot_toggle = idle_run && idle_zero;

  dwell_timer #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_idle (
    .clk  (clk),
    .rst  (1'b1),
    .load (idle_load),
    .zero (idle_zero)
  );
`else
  assign rot_toggle = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      sel_q   <= SEL_DICE;
      pulse_q <= 1'b0;
      last_q  <= SEL_LIGHTS;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pulse_q <= pulse_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_dice && req_lights) begin
          state_d = (last_q == SEL_LIGHTS) ? GNT_DICE : GNT_LIGHTS;
        end else if (req_dice) begin
          state_d = GNT_DICE;
        end else if (req_lights) begin
          state_d = GNT_LIGHTS;
        end
      end
      GNT_DICE: begin
        if (dwell_zero) begin
          if (req_lights) begin
            state_d = GNT_LIGHTS;
          end else if (!req_dice) begin
            state_d = IDLE;
          end
        end
      end
      GNT_LIGHTS: begin
        if (dwell_zero) begin
          if (req_dice) begin
            state_d = GNT_DICE;
          end else if (!req_lights) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_d   = sel_q;
    pulse_d = 1'b0;
    last_d  = last_q;
    load    = 1'b0;
    if (state_d != IDLE) begin
      sel_d   = sel_of(state_d);
      // Reload on a fresh grant or on a decision edge that keeps it.
      load    = (state_q == IDLE) || dwell_zero;
      pulse_d = (state_d != state_q);
      if (pulse_d) begin
        last_d = sel_of(state_d);
      end
    end else if (rot_toggle) begin
      sel_d = ~sel_q;
    end
  end

  assign sel          = sel_q;
  assign gnt_dice     = (state_q == GNT_DICE);
  assign gnt_lights   = (state_q == GNT_LIGHTS);
  assign busy         = gnt_dice || gnt_lights;
  assign switch_pulse = pulse_q;

endmodule
